// File: rtl/serial_port_controller_pkg.sv
// Shared peripheral package: UART strobe controller state/constants and the
// SRAM controller types that arbitrate the shared base_ram_data lines.
package serial_port_controller_pkg;

    localparam int unsigned UART_RD_PULSE_DEFAULT = 32'd2;
    localparam int unsigned UART_WR_PULSE_DEFAULT = 32'd2;
    localparam int unsigned PULSE_CNT_W           = 32'd4;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ACQ       = 4'd1,
        RD_WAIT   = 4'd2,
        RD_LOW    = 4'd3,
        WR_SETUP  = 4'd4,
        WR_LOW    = 4'd5,
        WR_HOLD   = 4'd6,
        WAIT_TBRE = 4'd7,
        WAIT_TSRE = 4'd8,
        DONE      = 4'd9
    } sp_state_e;

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } sp_req_t;

    typedef enum logic [1:0] {
        SRAM_OWNER_NONE = 2'd0,
        SRAM_OWNER_CPU  = 2'd1,
        SRAM_OWNER_UART = 2'd2
    } sram_owner_e;

    typedef struct packed {
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic [19:0] addr;
    } sram_ctrl_t;

    // Counters count down to zero, so a pulse of N cycles loads N-1.
    function automatic logic [PULSE_CNT_W-1:0] pulse_load(input int unsigned cyc);
        return PULSE_CNT_W'(cyc - 32'd1);
    endfunction

endpackage

// File: rtl/serial_port_controller_sync2.sv
// Two-flop synchroniser for the asynchronous CPLD status lines.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/serial_port_controller.sv
// CPU byte requests turned into CPLD UART read/write strobes on the
// base_ram_data[7:0] lines borrowed from the SRAM controller.
module serial_port_controller
    import serial_port_controller_pkg::*;
#(
    parameter int unsigned RD_PULSE_CYC = UART_RD_PULSE_DEFAULT,
    parameter int unsigned WR_PULSE_CYC = UART_WR_PULSE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       stat_rx_avail,
    output logic       stat_tx_idle,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       uart_rdn,
    output logic       uart_wrn,
    input  logic       uart_dataready,
    input  logic       uart_tbre,
    input  logic       uart_tsre,
    input  logic [7:0] uart_data_i,
    output logic [7:0] uart_data_o,
    output logic       uart_data_oe
);

    localparam logic [PULSE_CNT_W-1:0] RD_LOAD = pulse_load(RD_PULSE_CYC);
    localparam logic [PULSE_CNT_W-1:0] WR_LOAD = pulse_load(WR_PULSE_CYC);

    sp_state_e              state_r;
    sp_state_e              state_s;
    logic [PULSE_CNT_W-1:0] cnt_r;
    logic [PULSE_CNT_W-1:0] cnt_s;
    sp_req_t                req_r;
    logic                   accept_s;
    logic                   capture_s;
    logic                   rx_avail_s;
    logic                   tbre_s;
    logic                   tsre_s;
    logic                   rdn_s;
    logic                   wrn_s;
    logic                   oe_s;
    logic [7:0]             data_o_s;

    sync2 u_sync_rx   (.clk(clk), .rst_n(rst_n), .d(uart_dataready), .q(rx_avail_s));
    sync2 u_sync_tbre (.clk(clk), .rst_n(rst_n), .d(uart_tbre),      .q(tbre_s));
    sync2 u_sync_tsre (.clk(clk), .rst_n(rst_n), .d(uart_tsre),      .q(tsre_s));

    assign stat_rx_avail = rx_avail_s;
    assign stat_tx_idle  = tbre_s && tsre_s;

    // Next-state, pulse counter and next-output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept_s = 1'b1;
                    state_s  = ACQ;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACQ: begin
                if (!bus_gnt) begin
                    state_s = ACQ;
                end else if (req_r.we) begin
                    state_s = WR_SETUP;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Grant may still be withdrawn here: fall back and re-request.
                if (!bus_gnt) begin
                    state_s = ACQ;
                end else if (rx_avail_s) begin
                    state_s = RD_LOW;
                    cnt_s   = RD_LOAD;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            RD_LOW: begin
                if (cnt_r == {PULSE_CNT_W{1'b0}}) begin
                    capture_s = 1'b1;
                    state_s   = DONE;
                end else begin
                    cnt_s     = cnt_r - {{(PULSE_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WR_SETUP: begin
                state_s = WR_LOW;
                cnt_s   = WR_LOAD;
            end
            WR_LOW: begin
                if (cnt_r == {PULSE_CNT_W{1'b0}}) begin
                    state_s = WR_HOLD;
                end else begin
                    cnt_s   = cnt_r - {{(PULSE_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WR_HOLD: begin
                state_s = WAIT_TBRE;
            end
            WAIT_TBRE: begin
                if (tbre_s) begin
                    state_s = WAIT_TSRE;
                end else begin
                    state_s = WAIT_TBRE;
                end
            end
            WAIT_TSRE: begin
                if (tsre_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT_TSRE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins line up with state_r.
        rdn_s    = (state_s != RD_LOW);
        wrn_s    = (state_s != WR_LOW);
        oe_s     = (state_s == WR_SETUP) || (state_s == WR_LOW) || (state_s == WR_HOLD);
        data_o_s = oe_s ? req_r.data : 8'h00;
    end

    // State, pulse counter, request latch and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {PULSE_CNT_W{1'b0}};
            req_r      <= '0;
            resp_rdata <= 8'h00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                req_r <= '{we: req_we, data: req_wdata};
            end
            if (capture_s) begin
                resp_rdata <= uart_data_i;
            end
        end
    end

    // Registered pin drivers; reset releases both strobes and the data bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_rdn     <= 1'b1;
            uart_wrn     <= 1'b1;
            uart_data_oe <= 1'b0;
            uart_data_o  <= 8'h00;
            bus_req      <= 1'b0;
            resp_valid   <= 1'b0;
            req_ready    <= 1'b1;
        end else begin
            uart_rdn     <= rdn_s;
            uart_wrn     <= wrn_s;
            uart_data_oe <= oe_s;
            uart_data_o  <= data_o_s;
            bus_req      <= (state_s != IDLE);
            resp_valid   <= (state_s == DONE);
            req_ready    <= (state_s == IDLE);
        end
    end

endmodule
